instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word address of the request; held stable while imem_req=1 and imem_ack=0.
REQ-006 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 redirect  input  1  taken branch or jump from execute; flushes the fetch stream.
REQ-009 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-010 instr_valid  output  1  instruction and instr_pc hold a valid entry.
REQ-011 instr_ready  input  1  decode/top consumes the entry when instr_valid=1.
REQ-012 instruction  output  32  head instruction word, fed to the core's instruction input.
REQ-013 instr_pc  output  32  address of the head instruction.
REQ-014 fetch_fault  output  1  sticky misaligned-redirect flag; exists only under REQ-032.

Function
REQ-015 The block SHALL contain a 2-entry FIFO of {pc, instruction}; instruction/instr_pc SHALL show the head entry, and instr_valid SHALL equal (count != 0).
REQ-016 The FSM SHALL have states RUN, DROP and HALT, with HALT used only under REQ-032.
REQ-017 In RUN, imem_req SHALL be 1 when registered count < 2 and imem_addr SHALL equal fetch_pc; neither SHALL depend combinationally on imem_ack, instr_ready or redirect.
REQ-018 When RUN, imem_req=1, imem_ack=1 and redirect=0, the block SHALL push {fetch_pc, imem_rdata} and SHALL set fetch_pc to fetch_pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 A pop SHALL occur when instr_valid=1, instr_ready=1 and redirect=0; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-020 Latency: with a zero-wait ack, instr_valid SHALL rise 1 cycle after the accepted request.
REQ-021 Throughput: with a zero-wait ack and instr_ready held at 1, the block SHALL deliver 1 instruction per cycle.
REQ-022 On redirect=1, the FIFO SHALL be emptied on the next edge, fetch_pc SHALL load redirect_pc, and any pop or push in that cycle SHALL be discarded.
REQ-023 If redirect=1 while imem_req=1 and imem_ack=0, the FSM SHALL enter DROP.
REQ-024 In DROP, imem_req SHALL stay 1 with the old imem_addr until imem_ack; the returned data SHALL be discarded, and the FSM SHALL then return to RUN and fetch from fetch_pc.
REQ-025 A redirect while in DROP SHALL update fetch_pc and SHALL keep the FSM in DROP.
REQ-026 A redirect in the same cycle as imem_ack SHALL discard the data and SHALL stay in or return to RUN.
REQ-027 imem_req SHALL never be 1 while count == 2.

Reset
REQ-028 While rst=1, the block SHALL hold: state RUN, count 0, fetch_pc RESET_PC, instr_valid 0, instruction 0, instr_pc 0, fetch_fault 0.
REQ-029 While rst=1, imem_req SHALL be 0, and it SHALL assert on the first cycle after rst deasserts.
REQ-030 Reset asserted mid-handshake SHALL abandon the request immediately, with no completion required.

Configuration
REQ-031 The macro FETCH_MISALIGN_CHECK_EN SHALL compile the misaligned-redirect check in or out.
REQ-032 With FETCH_MISALIGN_CHECK_EN defined, redirect with redirect_pc[1:0] != 0 SHALL flush as in REQ-022, set fetch_fault=1 and enter HALT.
REQ-033 In HALT, imem_req SHALL be 0; only an aligned redirect (which clears fetch_fault and enters RUN) or rst SHALL leave HALT.
REQ-034 With FETCH_MISALIGN_CHECK_EN undefined, redirect_pc[1:0] SHALL be forced to 2'b00, and the fetch_fault port and HALT state SHALL be absent.

Structure
REQ-035 Package fetch_pkg SHALL hold the FSM state enum (RUN, DROP, HALT), the FIFO depth constant (2) and the PC increment constant (4).
REQ-036 The FIFO SHALL be sub-module fetch_fifo, with ports push, pop, flush, data in/out, count, and 64-bit entries.

Verification
REQ-037 Reset release, zero-wait ack, imem_rdata 32'h3e800093, ready=1 -> first imem_addr=0; next cycle instr_valid=1, instruction=32'h3e800093, instr_pc=0.
REQ-038 ready=0 for 4 cycles, ack always 1 -> exactly 2 pushes (pc 0, 4); imem_req=0 while full; release ready -> pcs 0, 4, 8 in order.
REQ-039 Memory stalls ack 3 cycles, redirect to 32'h100 during the stall -> DROP; old addr held until ack; data discarded; next imem_addr=32'h100.
REQ-040 Redirect and ack in the same cycle, redirect_pc=32'h40 -> no push; FIFO empty; next imem_addr=32'h40.
REQ-041 Redirect to 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC, then 32'h0000_0000.
REQ-042 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> fetch_fault=1, imem_req=0; aligned redirect to 32'h200 -> fetch_fault=0, imem_addr=32'h200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (HALT only with FETCH_MISALIGN_CHECK_EN)
//   fetch_entry_t : one prefetch FIFO entry, {pc, instruction}
//   FIFO_DEPTH    : prefetch FIFO depth
//   FIFO_FULL     : FIFO_DEPTH at the width of the FIFO occupancy count
//   PC_INC        : sequential fetch address increment
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds the HALT state).
package fetch_pkg;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [1:0]  FIFO_FULL  = 2'(FIFO_DEPTH);
  localparam logic [31:0] PC_INC     = 32'd4;

  typedef enum logic [1:0] {
    RUN,
    DROP
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    HALT
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request bus.
//   req   : fetch request (fetch unit -> memory)
//   addr  : word address of the request, stable while req=1 and ack=0
//   ack   : memory accepts the request and returns rdata in the same cycle
//   rdata : instruction word, valid with ack
// Modports: master (fetch unit side), slave (memory side).
interface instr_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry prefetch FIFO of 64-bit {pc, instruction} entries.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   wdata    : entry to write
//   rdata    : head entry (stale when count is 0)
//   count    : number of stored entries
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [1:0]  count
);

  logic [63:0] mem [FIFO_DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && (count != FIFO_FULL);
  assign do_pop  = pop && (count != 2'd0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: storage is reset too, because the head entry is a visible output that must read 0 in reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential prefetch into a 2-entry FIFO, with
// redirect/flush from execute and drop of a request stalled by a redirect.
//   clk, rst    : clock, asynchronous active-high reset
//   imem        : instruction memory bus (master side)
//   redirect    : taken branch/jump, flushes the fetch stream
//   redirect_pc : new fetch address, sampled with redirect
//   instr_valid : head entry valid
//   instr_ready : consumer takes the head entry
//   instruction : head instruction word
//   instr_pc    : head instruction address
//   fetch_fault : sticky misaligned-redirect flag (FETCH_MISALIGN_CHECK_EN only)
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. Without it redirect_pc[1:0]
// is forced to zero and there is no fetch_fault port and no HALT state.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                 fetch_fault,
`endif
  instr_fetch_if.master        imem,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instruction,
  output logic [31:0]          instr_pc
);

  fetch_state_e state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  drop_addr, drop_addr_next;
  logic [31:0]  target_pc;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t new_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault, fault_next;
  logic misaligned;
  assign misaligned  = redirect_pc[1:0] != 2'b00;
  assign target_pc   = redirect_pc;
  assign fetch_fault = fault;
`else
  assign target_pc = {redirect_pc[31:2], 2'b00};
`endif

  // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    drop_addr_next = drop_addr;
    imem.req       = 1'b0;
    imem.addr      = fetch_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_next     = fault;
`endif
    unique case (state)
      RUN:  imem.req = (count != FIFO_FULL);
      // A request stalled by a redirect must still complete at its old address.
      DROP: begin
        imem.req  = 1'b1;
        imem.addr = drop_addr;
        if (imem.ack) state_next = RUN;
      end
      default: imem.req = 1'b0;
    endcase
    if (rst) imem.req = 1'b0;

    push = (state == RUN) && imem.req && imem.ack && !redirect;
    if (push) fetch_pc_next = fetch_pc + PC_INC;

    if (redirect) begin
      fetch_pc_next = target_pc;
      if (imem.req && !imem.ack) begin
        state_next = DROP;
        // In DROP the address being held is already in drop_addr.
        if (state == RUN) drop_addr_next = fetch_pc;
      end else begin
        state_next = RUN;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_next = misaligned;
      if (misaligned) state_next = HALT;
`endif
    end
  end

  assign pop = instr_valid && instr_ready && !redirect;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault     <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault     <= fault_next;
`endif
    end
  end

  assign new_entry = '{pc: fetch_pc, instr: imem.rdata};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (new_entry),
    .rdata (head),
    .count (count)
  );

  assign instr_valid = count != 2'd0;
  assign instruction = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset and
// configuration sequences, and randomized traffic against a queue-based model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_fault (fetch_fault),
`endif
    .imem        (imem_bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic apply(input logic rd, input logic [31:0] rpc, input logic ack,
                       input logic rdy, input logic [31:0] rdata);
    redirect       = rd;
    redirect_pc    = rpc;
    imem_bus.ack   = ack;
    imem_bus.rdata = rdata;
    instr_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  // Behavioural model state for the random phase.
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_drop_addr;
  bit          m_dropping;

  localparam logic [31:0] R0 = 32'h3e80_0093, R1 = 32'h0000_0013, R2 = 32'h0010_0093;
  localparam logic [31:0] R3 = 32'h0020_0113, R4 = 32'h0030_0193, R5 = 32'h0040_0213;
  localparam logic [31:0] RX = 32'hdead_beef, R7 = 32'h0050_0293, R8 = 32'h0060_0313;
  localparam logic [31:0] R9 = 32'h0070_0393, RA = 32'hbaad_f00d, RB = 32'h0080_0413;
  localparam logic [31:0] RC = 32'h0090_0493;

  initial begin
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        r_rd, r_ack, r_rdy;
    logic [31:0] r_pc, r_data;

    //          rd    rpc            ack   rdy   rdata  req   addr           valid instr pc
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, R0,    1'b1, 32'h4,         1'b1, R0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, R1,    1'b0, 32'h8,         1'b1, R0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, R2,    1'b0, 32'h8,         1'b1, R0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, R2,    1'b0, 32'h8,         1'b1, R0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, R2,    1'b0, 32'h8,         1'b1, R0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, R2,    1'b1, 32'h8,         1'b1, R1, 32'h4};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, R2,    1'b1, 32'hc,         1'b1, R2, 32'h8};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, R3,    1'b1, 32'hc,         1'b0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, R3,    1'b1, 32'h10,        1'b1, R3, 32'hc};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, R4,    1'b1, 32'h14,        1'b1, R4, 32'h10};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, R5,    1'b1, 32'h18,        1'b1, R5, 32'h14};
    vecs[11] = '{1'b1, 32'h40,       1'b1, 1'b1, RX,    1'b1, 32'h40,        1'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, R7,    1'b1, 32'h44,        1'b1, R7, 32'h40};
    vecs[13] = '{1'b1, 32'hffff_fffc, 1'b1, 1'b0, RX,   1'b1, 32'hffff_fffc, 1'b0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b0, R8,    1'b1, 32'h0,         1'b1, R8, 32'hffff_fffc};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, R9,    1'b1, 32'h4,         1'b1, R9, 32'h0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, RX,    1'b1, 32'h4,         1'b0, 32'h0, 32'h0};
    vecs[17] = '{1'b1, 32'h100,      1'b0, 1'b1, RX,    1'b1, 32'h4,         1'b0, 32'h0, 32'h0};
    vecs[18] = '{1'b0, 32'h0,        1'b0, 1'b1, RX,    1'b1, 32'h4,         1'b0, 32'h0, 32'h0};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b1, RA,    1'b1, 32'h100,       1'b0, 32'h0, 32'h0};
    vecs[20] = '{1'b0, 32'h0,        1'b1, 1'b0, RB,    1'b1, 32'h104,       1'b1, RB, 32'h100};
    vecs[21] = '{1'b1, 32'h300,      1'b0, 1'b0, RX,    1'b1, 32'h104,       1'b0, 32'h0, 32'h0};
    vecs[22] = '{1'b1, 32'h500,      1'b0, 1'b0, RX,    1'b1, 32'h104,       1'b0, 32'h0, 32'h0};
    vecs[23] = '{1'b1, 32'h600,      1'b1, 1'b0, RX,    1'b1, 32'h600,       1'b0, 32'h0, 32'h0};
    vecs[24] = '{1'b0, 32'h0,        1'b1, 1'b1, RC,    1'b1, 32'h604,       1'b1, RC, 32'h600};

    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset req", imem_bus.req, 1'b0);
    check("reset valid", instr_valid, 1'b0);
    check("reset instruction", instruction, 32'h0);
    check("reset instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("reset fault", fetch_fault, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release req", imem_bus.req, 1'b1);
    check("release addr", imem_bus.addr, 32'h0);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].rdy, vecs[i].rdata);
      check($sformatf("v%0d req", i), imem_bus.req, vecs[i].exp_req);
      check($sformatf("v%0d addr", i), imem_bus.addr, vecs[i].exp_addr);
      check($sformatf("v%0d valid", i), instr_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d instruction", i), instruction, vecs[i].exp_instr);
        check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].exp_pc);
      end
    end

    // Reset asserted mid-handshake abandons the request at once.
    apply(1'b0, 32'h0, 1'b0, 1'b0, RX);
    check("stall req", imem_bus.req, 1'b1);
    rst = 1'b1;
    #1;
    check("midreset req", imem_bus.req, 1'b0);
    check("midreset valid", instr_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rerelease req", imem_bus.req, 1'b1);
    check("rerelease addr", imem_bus.addr, 32'h0);

    // Randomized traffic against the queue model.
    q.delete();
    m_pc = 32'h0;
    m_drop_addr = 32'h0;
    m_dropping = 1'b0;
    for (int c = 0; c < 600; c++) begin
      exp_req  = m_dropping || (q.size() < 2);
      exp_addr = m_dropping ? m_drop_addr : m_pc;
      check("rnd req", imem_bus.req, exp_req);
      check("rnd addr", imem_bus.addr, exp_addr);
      check("rnd valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("rnd instruction", instruction, q[0].instr);
        check("rnd instr_pc", instr_pc, q[0].pc);
      end
      r_rd   = $urandom_range(7) == 0;
      r_pc   = ($urandom_range(3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
      r_ack  = $urandom_range(3) != 0;
      r_rdy  = $urandom_range(2) != 0;
      r_data = $urandom;
      if (r_rd) begin
        if (!m_dropping && exp_req && !r_ack) begin
          m_dropping  = 1'b1;
          m_drop_addr = m_pc;
        end else if (m_dropping && r_ack) begin
          m_dropping = 1'b0;
        end
        q.delete();
        m_pc = r_pc;
      end else if (m_dropping) begin
        if (r_ack) m_dropping = 1'b0;
      end else begin
        if (q.size() != 0 && r_rdy) void'(q.pop_front());
        if (exp_req && r_ack) begin
          q.push_back('{pc: m_pc, instr: r_data});
          m_pc = m_pc + 32'd4;
        end
      end
      apply(r_rd, r_pc, r_ack, r_rdy, r_data);
    end

    // Redirect target alignment handling.
`ifdef FETCH_MISALIGN_CHECK_EN
    apply(1'b1, 32'h102, 1'b1, 1'b1, RX);
    check("misalign fault", fetch_fault, 1'b1);
    check("misalign req", imem_bus.req, 1'b0);
    check("misalign valid", instr_valid, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 1'b1, RX);
    check("halt req", imem_bus.req, 1'b0);
    check("halt fault", fetch_fault, 1'b1);
    apply(1'b1, 32'h200, 1'b0, 1'b1, RX);
    check("unhalt fault", fetch_fault, 1'b0);
    check("unhalt req", imem_bus.req, 1'b1);
    check("unhalt addr", imem_bus.addr, 32'h200);
`else
    apply(1'b1, 32'h703, 1'b1, 1'b1, RX);
    check("force-align req", imem_bus.req, 1'b1);
    check("force-align addr", imem_bus.addr, 32'h700);
    check("force-align valid", instr_valid, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 1'b0, R7);
    check("force-align head valid", instr_valid, 1'b1);
    check("force-align head pc", instr_pc, 32'h700);
    check("force-align next addr", imem_bus.addr, 32'h704);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
